// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg
//   Shared types and constants for the AHB-Lite to APB3 bridge:
//   - state_t : bridge FSM state encoding
//   - HTRANS_* : AHB transfer type codes
//   - HRESP_*  : AHB response codes
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR1   = 3'd5,
        ST_ERR2   = 3'd6
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_to_apb_bridge.sv
// ahb_to_apb_bridge
//   AHB-Lite slave that turns single AHB transfers into APB3 transfers,
//   one at a time. APB outputs are registered; AHB outputs are decoded
//   from the state register only (no PREADY/PRDATA -> AHB comb path).
//
// Ports
//   HCLK, HRESET            clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS,    AHB address phase inputs
//   HWRITE, HREADY
//   HWDATA                  AHB write data (data phase)
//   HREADYOUT, HRESP,       AHB slave response
//   HRDATA
//   PSEL, PENABLE, PWRITE,  APB requester outputs
//   PADDR, PWDATA
//   PRDATA, PREADY, PSLVERR APB completer response
//   dbg_state               current FSM state, for observation only
//
// Handshake: an AHB transfer is taken when HSEL & HTRANS[1] & HREADY in a
// state that owns no pending transfer (IDLE, DONE, ERR2). An APB transfer
// completes on the ACCESS cycle where PREADY is high; PSLVERR is only
// meaningful in that cycle.
module ahb_to_apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic          HREADY,
    input  logic [DW-1:0] HWDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [DW-1:0] HRDATA,
    output logic          PSEL,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [AW-1:0] PADDR,
    output logic [DW-1:0] PWDATA,
    input  logic [DW-1:0] PRDATA,
    input  logic          PREADY,
    input  logic          PSLVERR,
    output state_t        dbg_state
);

    state_t state_q;
    state_t state_d;

    logic accept;
    logic can_accept;
    logic take;

    // Upper address bits and HTRANS[0] (SEQ vs NONSEQ) do not matter here.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, HADDR[31:AW], HTRANS[0]};

    assign accept     = HSEL & HTRANS[1] & HREADY;
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                        (state_q == ST_ERR2);
    assign take       = accept & can_accept;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_LATCH;
            ST_LATCH:  state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (PREADY) state_d = PSLVERR ? ST_ERR1 : ST_DONE;
            ST_DONE:   state_d = accept ? ST_LATCH : ST_IDLE;
            ST_ERR1:   state_d = ST_ERR2;
            ST_ERR2:   state_d = accept ? ST_LATCH : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            HRDATA  <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                PADDR  <= HADDR[AW-1:0];
                PWRITE <= HWRITE;
            end
            // HWDATA is only valid in the first data-phase cycle.
            if (state_q == ST_LATCH && PWRITE) begin
                PWDATA <= HWDATA;
            end
            if (state_q == ST_ACCESS && PREADY && !PSLVERR && !PWRITE) begin
                HRDATA <= PRDATA;
            end
        end
    end

    assign HREADYOUT = can_accept;
    assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ?
                       HRESP_ERROR : HRESP_OKAY;
    assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE   = (state_q == ST_ACCESS);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// tb_ahb_to_apb_bridge
//   Self-checking bench for ahb_to_apb_bridge. Expected HRDATA after each
//   transfer is pushed when the transfer is issued and popped when the
//   bridge completes it.
module tb_ahb_to_apb_bridge;
    import ahb_apb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          HCLK;
    logic          HRESET;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic          HREADY;
    logic [DW-1:0] HWDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic [DW-1:0] HRDATA;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    state_t        dbg_state;

    ahb_to_apb_bridge #(.AW(AW), .DW(DW)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .dbg_state (dbg_state)
    );

    // Single slave on the bus: the mux feeds our own HREADYOUT back.
    assign HREADY = HREADYOUT;

    // ---------------- clock / reset ----------------
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_hrdata;
    logic [DW-1:0] m_pwdata;
    logic [AW-1:0] m_paddr;
    logic          m_pwrite;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hrdata = '0;
        m_pwdata = '0;
        m_paddr  = '0;
        m_pwrite = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- driver ----------------
    // Issues the address phase in the current cycle (bridge must be able to
    // accept) and runs the data phase until HREADYOUT returns high.
    // Returns at the completing cycle (DONE or ERR2), #1 after the edge.
    task automatic xfer(input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input int stall,
                        input logic err, input logic [31:0] rdata,
                        output int waits, output int pen, output int setup_at,
                        output int done_at);
        int n;
        int acc;
        int err1_seen;
        logic [DW-1:0] exp_rd;
        waits = 0; pen = 0; setup_at = -1; done_at = -1;
        n = 0; acc = 0; err1_seen = 0;

        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = addr; HWRITE = wr;
        m_paddr  = addr[AW-1:0];
        m_pwrite = wr;
        if (wr) m_pwdata = wdata;
        if (!wr && !err) m_hrdata = rdata;
        exp_q.push_back(m_hrdata);

        do begin
            tick();
            n++;
            if (n == 1) begin
                HSEL = 1'b0; HTRANS = HTRANS_IDLE; HADDR = $urandom;
                HWRITE = $urandom_range(0, 1);
                HWDATA = wr ? wdata : $urandom;
            end
            if (!HREADYOUT) waits++;
            if (HRESP && !HREADYOUT) err1_seen++;
            if (dbg_state == ST_SETUP && setup_at < 0) setup_at = n;
            if (PSEL) begin
                check("paddr", {16'h0, PADDR}, {16'h0, m_paddr});
                check("pwrite", {31'h0, PWRITE}, {31'h0, m_pwrite});
                check("pwdata", PWDATA, m_pwdata);
            end
            if (PENABLE) begin
                pen++;
                PREADY  = (acc >= stall);
                PSLVERR = err & PREADY;
                PRDATA  = PREADY ? rdata : $urandom;
                acc++;
            end else begin
                PREADY  = $urandom_range(0, 1);
                PSLVERR = $urandom_range(0, 1);
                PRDATA  = $urandom;
            end
        end while (!HREADYOUT && n < 40);

        PREADY = 1'b0; PSLVERR = 1'b0;
        if (!HREADYOUT) begin
            check("xfer_timeout", 32'd0, 32'd1);
        end else begin
            done_at = n;
            check("end_hresp", {31'h0, HRESP}, {31'h0, err});
            check("end_state", {29'h0, dbg_state},
                  {29'h0, (err ? ST_ERR2 : ST_DONE)});
            check("err1_cycles", err1_seen, {31'h0, err});
        end
        exp_rd = exp_q.pop_front();
        check("hrdata", HRDATA, exp_rd);
    endtask

    // ---------------- stimulus ----------------
    int waits, pen, setup_at, done_at;
    int stall;
    logic wr, err;
    logic [31:0] addr, wdata, rdata;

    initial begin
        HSEL = 0; HADDR = 0; HTRANS = HTRANS_IDLE; HWRITE = 0; HWDATA = 0;
        PRDATA = 0; PREADY = 0; PSLVERR = 0;
        HRESET = 1'b1;
        model_reset();
        tick(); tick();
        HRESET = 1'b0;

        // reset values
        check("rst_hreadyout", {31'h0, HREADYOUT}, 32'd1);
        check("rst_hresp", {31'h0, HRESP}, 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        check("rst_psel_pen", {30'h0, PSEL, PENABLE}, 32'd0);
        check("rst_pwrite", {31'h0, PWRITE}, 32'd0);
        check("rst_paddr", {16'h0, PADDR}, 32'd0);
        check("rst_pwdata", PWDATA, 32'd0);
        check("rst_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});

        // zero-wait read
        xfer(32'h4000_1234, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF,
             waits, pen, setup_at, done_at);
        check("rd_waits", waits, 32'd3);
        check("rd_done_at", done_at, 32'd4);
        check("rd_setup_at", setup_at, 32'd2);
        check("rd_pen", pen, 32'd1);
        tick();

        // write with 3 stall cycles
        xfer(32'h4000_0008, 1'b1, 32'h0000_00A5, 3, 1'b0, 32'h0,
             waits, pen, setup_at, done_at);
        check("wr_waits", waits, 32'd6);
        check("wr_pen", pen, 32'd4);
        tick();

        // read with PSLVERR: HRDATA keeps DEADBEEF
        xfer(32'h4000_0100, 1'b0, 32'h0, 1, 1'b1, 32'h1234_5678,
             waits, pen, setup_at, done_at);
        check("err_waits", waits, 32'd5);
        check("err_hrdata_kept", HRDATA, 32'hDEAD_BEEF);
        tick();

        // back-to-back write then read issued in the write's DONE cycle
        xfer(32'h4000_0010, 1'b1, 32'hCAFE_0001, 0, 1'b0, 32'h0,
             waits, pen, setup_at, done_at);
        xfer(32'h4000_0020, 1'b0, 32'h0, 1, 1'b0, 32'h5555_AAAA,
             waits, pen, setup_at, done_at);
        check("b2b_setup_at", setup_at, 32'd2);
        check("b2b_waits", waits, 32'd4);
        // a transfer issued straight out of ERR2
        xfer(32'h4000_0030, 1'b0, 32'h0, 0, 1'b1, 32'h0BAD_0BAD,
             waits, pen, setup_at, done_at);
        xfer(32'h4000_0034, 1'b1, 32'h7777_1111, 2, 1'b0, 32'h0,
             waits, pen, setup_at, done_at);
        check("err2_b2b_waits", waits, 32'd5);
        tick();

        // reset in ACCESS with PREADY low
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h4000_0044; HWRITE = 1'b0;
        tick();
        HSEL = 1'b0; HTRANS = HTRANS_IDLE;
        tick(); tick();
        check("pre_rst_state", {29'h0, dbg_state}, {29'h0, ST_ACCESS});
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        model_reset();
        check("mid_rst_psel_pen", {30'h0, PSEL, PENABLE}, 32'd0);
        check("mid_rst_hreadyout", {31'h0, HREADYOUT}, 32'd1);
        check("mid_rst_state", {29'h0, dbg_state}, {29'h0, ST_IDLE});
        check("mid_rst_paddr", {16'h0, PADDR}, 32'd0);
        check("mid_rst_hrdata", HRDATA, 32'd0);

        // no APB activity: BUSY with HSEL=1, then NONSEQ with HSEL=0
        HSEL = 1'b1; HTRANS = HTRANS_BUSY; HADDR = 32'h4000_0050;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("busy_psel", {31'h0, PSEL}, 32'd0);
            check("busy_hready", {30'h0, HREADYOUT, HRESP}, 32'd2);
        end
        HSEL = 1'b0; HTRANS = HTRANS_NONSEQ;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nosel_psel", {31'h0, PSEL}, 32'd0);
            check("nosel_hready", {30'h0, HREADYOUT, HRESP}, 32'd2);
        end
        HTRANS = HTRANS_IDLE;
        tick();

        // random transfers, sometimes back-to-back
        for (int i = 0; i < 20; i++) begin
            wr    = $urandom_range(0, 1);
            err   = ($urandom_range(0, 3) == 0);
            stall = $urandom_range(0, 3);
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            xfer(addr, wr, wdata, stall, err, rdata, waits, pen, setup_at, done_at);
            check("rnd_waits", waits, 32'(3 + stall + int'(err)));
            check("rnd_pen", pen, 32'(stall + 1));
            if ($urandom_range(0, 1) == 1) tick();
        end

        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_to_apb_bridge.md
# ahb_to_apb_bridge

AHB-Lite slave that converts single AHB transfers into APB3 transfers for the SoC's low-speed peripherals (UART, GPIO, timer). It occupies one slave port of the AHB slave multiplexer, feeding it HREADYOUT/HRESP/HRDATA, and drives one APB segment. Operation is strictly one transfer at a time, with registered APB outputs and a two-cycle AHB ERROR response on PSLVERR.

## Interface
- AW, 16: APB address width; PADDR = HADDR[AW-1:0].
- DW, 32: data width. Fixed at 32.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  reset; synchronous, active-high.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  AHB address.
- HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ.
- HWRITE  in  1  write = 1.
- HREADY  in  1  bus HREADY, the mux HREADYOUT fed back.
- HWDATA  in  DW  write data, valid in the data phase.
- HREADYOUT  out  1  ready to the slave mux.
- HRESP  out  1  1 = ERROR.
- HRDATA  out  DW  read data.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  AW  APB address.
- PWDATA  out  DW  APB write data.
- PRDATA  in  DW  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error, sampled with PREADY.

## Operation
- Accept condition: HSEL & HTRANS[1] & HREADY. This captures HADDR[AW-1:0] and HWRITE into PADDR/PWRITE registers.
- HSIZE is ignored. Every access is a full 32-bit APB word.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. On accept, go to LATCH.
  - LATCH: first data-phase cycle. HREADYOUT=0. PWDATA <= HWDATA on writes; PWDATA is held on reads. Go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, HREADYOUT=0. Go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0. Stay while PREADY=0.
    - On PREADY & ~PSLVERR, go to DONE. On a read, also HRDATA <= PRDATA.
    - On PREADY & PSLVERR, go to ERR1.
  - DONE: HREADYOUT=1, HRESP=0, PSEL=0. On accept go to LATCH, else IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, PSEL=0. Go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. On accept go to LATCH, else IDLE.
- Accepts are evaluated only in IDLE, DONE and ERR2. HREADY is high in those states whenever this slave owns the data phase, so back-to-back transfers are supported.
- HRDATA holds its last read value. Writes and errors leave it unchanged.
- PADDR, PWRITE and PWDATA hold their values after a transfer ends.
- No timeout: a PREADY that never asserts stalls the bus indefinitely.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0. State = IDLE.
- HRESET asserted in any state, including mid-ACCESS, forces reset values in the next cycle. PSEL drops without completing the APB transfer.
- Zero-wait-state APB read, with address phase at cycle 0:
  - cycle 1 LATCH, cycle 2 SETUP, cycle 3 ACCESS (PREADY=1), cycle 4 DONE.
  - Result: 3 AHB wait states, with HREADYOUT=1 and valid HRDATA in cycle 4.
- Each PREADY=0 cycle in ACCESS adds exactly one AHB wait state.
- Error: the ACCESS cycle with PSLVERR is followed by ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1).
- HTRANS IDLE/BUSY, or HSEL=0, produces no APB activity. HREADYOUT stays 1 and HRESP stays 0.
- All outputs are registered or decoded directly from the state register. There is no combinational path from PREADY/PRDATA to AHB outputs.

## Structure
- Package ahb_apb_pkg holds:
  - the FSM state enum (IDLE, LATCH, SETUP, ACCESS, DONE, ERR1, ERR2);
  - HTRANS constants (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - HRESP constants (OKAY=0, ERROR=1).
- Single module, with no sub-modules.

## Test plan
- Read at HADDR=0x4000_1234, PRDATA=0xDEADBEEF, PREADY=1: PADDR=0x1234 in SETUP and ACCESS. HRDATA=0xDEADBEEF with HREADYOUT=1 exactly 4 cycles after the address phase.
- Write 0x0000_00A5 to 0x4000_0008, PREADY low for 3 ACCESS cycles: PWDATA=0xA5 and PWRITE=1 throughout SETUP/ACCESS. 6 wait states. PENABLE high for 4 cycles.
- Read with PSLVERR=1: ERR1 shows HREADYOUT=0/HRESP=1, ERR2 shows HREADYOUT=1/HRESP=1. HRDATA is unchanged from its prior value.
- Back-to-back write then read, with the read's address phase in the write's DONE cycle: the second SETUP starts 2 cycles after DONE, and PADDR/PWRITE update correctly.
- HRESET pulsed in ACCESS with PREADY=0: the next cycle shows PSEL=0, PENABLE=0, HREADYOUT=1, and state IDLE.
- HTRANS=BUSY with HSEL=1 and HTRANS=NONSEQ with HSEL=0: no PSEL assertion, and HREADYOUT stays 1.
